// File: rtl/fetch_pkg.sv
// Shared types for the instruction prefetch front end: fetch FSM states and
// the {pc, instr} entry stored in the prefetch FIFO.
package fetch_pkg;

   localparam int WIDTH = 20;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DISCARD
   } fetch_state_t;

   typedef struct packed {
      logic [WIDTH-1:0] pc;
      logic [WIDTH-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/instr_fifo.sv
// Show-ahead synchronous FIFO of fetched instructions with PC tags.
// Flush empties it in one cycle and overrides any same-cycle push or pop.
module instr_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  fetch_entry_t             push_entry,
   input  logic                     pop,
   input  logic                     flush,
   output fetch_entry_t             head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   fetch_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   // A pop frees a slot in the same cycle, so a full FIFO may still accept a push
   assign do_pop  = pop && (count != '0) && !flush;
   assign do_push = push && ((count != FULL_CNT) || do_pop) && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_entry;
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/instruction_prefetch_queue.sv
// Request/acknowledge instruction fetcher feeding a small prefetch FIFO
// drained by decode; a jump flushes the FIFO and redirects fetch.
module instruction_prefetch_queue #(
   parameter int               DEPTH    = 4,
   parameter int               WIDTH    = 20,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic                     Clock,
   input  logic                     Reset,
   input  logic                     JumpEnable,
   input  logic [WIDTH-1:0]         JumpAddress,
   output logic                     IMem_Req,
   output logic [WIDTH-1:0]         IMem_Address,
   input  logic                     IMem_Ack,
   input  logic [WIDTH-1:0]         IMem_Data,
   output logic                     Instr_Valid,
   input  logic                     Instr_Ready,
   output logic [WIDTH-1:0]         Instr_Out,
   output logic [WIDTH-1:0]         Instr_PC,
   output logic [$clog2(DEPTH):0]   Queue_Count
);

   import fetch_pkg::*;

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

   fetch_state_t     state;
   fetch_state_t     state_d;
   logic [WIDTH-1:0] fetch_pc;
   logic [WIDTH-1:0] fetch_pc_d;
   logic [WIDTH-1:0] address_d;
   logic             req_d;
   logic             ack_done;
   logic             pop_ok;
   logic             fifo_push;
   logic             fifo_pop;
   logic             fifo_flush;
   logic [CNT_W-1:0] occ_after_pop;
   fetch_entry_t     push_entry;
   fetch_entry_t     head;

   assign Instr_Valid   = (Queue_Count != '0);
   assign pop_ok        = Instr_Valid & Instr_Ready;
   assign ack_done      = IMem_Req & IMem_Ack;
   assign occ_after_pop = Queue_Count - CNT_W'(pop_ok);
   assign push_entry    = '{pc: fetch_pc, instr: IMem_Data};

   // Head storage is not reset, so mask it while the queue is empty
   assign Instr_Out = Instr_Valid ? head.instr : '0;
   assign Instr_PC  = Instr_Valid ? head.pc    : '0;

   always_comb begin
      state_d    = state;
      fetch_pc_d = fetch_pc;
      fifo_push  = 1'b0;
      fifo_pop   = pop_ok & ~JumpEnable;
      fifo_flush = JumpEnable;

      if (JumpEnable) begin
         fetch_pc_d = JumpAddress;
         case (state)
            IDLE:    state_d = FETCH;
            FETCH:   state_d = ack_done ? FETCH : DISCARD;
            DISCARD: state_d = DISCARD;
            default: state_d = IDLE;
         endcase
      end else begin
         case (state)
            IDLE: begin
               if (occ_after_pop < DEPTH_CNT) begin
                  state_d = FETCH;
               end
            end
            FETCH: begin
               if (ack_done) begin
                  fifo_push  = 1'b1;
                  fetch_pc_d = fetch_pc + WIDTH'(1);
                  // Keep requesting only while a slot stays reserved for the next ack
                  state_d    = ((occ_after_pop + CNT_W'(1)) < DEPTH_CNT) ? FETCH : IDLE;
               end
            end
            DISCARD: begin
               if (ack_done) begin
                  state_d = FETCH;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      req_d     = (state_d != IDLE);
      address_d = (state_d == FETCH) ? fetch_pc_d : IMem_Address;
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state        <= IDLE;
         fetch_pc     <= RESET_PC;
         IMem_Req     <= 1'b0;
         IMem_Address <= '0;
      end else begin
         state        <= state_d;
         fetch_pc     <= fetch_pc_d;
         IMem_Req     <= req_d;
         IMem_Address <= address_d;
      end
   end

   instr_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk       (Clock),
      .rst_n     (Reset),
      .push      (fifo_push),
      .push_entry(push_entry),
      .pop       (fifo_pop),
      .flush     (fifo_flush),
      .head      (head),
      .count     (Queue_Count)
   );

endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// Bench for instruction_prefetch_queue: directed scenarios plus random traffic
// compared each cycle against a queue-based reference model.
module tb_instruction_prefetch_queue;

   localparam int DEPTH = 4;
   localparam int W     = 20;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n = 1'b1;
   logic         jump_en, ack, ready;
   logic [W-1:0] jump_addr, mdata;
   logic         req, valid;
   logic [W-1:0] addr, iout, ipc;
   logic [2:0]   qcnt;

   logic         w_ack, w_ready, w_jump, w_req, w_valid;
   logic [W-1:0] w_jaddr, w_data, w_addr, w_out, w_pc;
   logic [2:0]   w_cnt;

   instruction_prefetch_queue #(.DEPTH(DEPTH), .WIDTH(W), .RESET_PC(20'h00000)) dut (
      .Clock(clk), .Reset(rst_n), .JumpEnable(jump_en), .JumpAddress(jump_addr),
      .IMem_Req(req), .IMem_Address(addr), .IMem_Ack(ack), .IMem_Data(mdata),
      .Instr_Valid(valid), .Instr_Ready(ready), .Instr_Out(iout), .Instr_PC(ipc),
      .Queue_Count(qcnt)
   );

   instruction_prefetch_queue #(.DEPTH(DEPTH), .WIDTH(W), .RESET_PC(20'hFFFFE)) dut_wrap (
      .Clock(clk), .Reset(rst_n), .JumpEnable(w_jump), .JumpAddress(w_jaddr),
      .IMem_Req(w_req), .IMem_Address(w_addr), .IMem_Ack(w_ack), .IMem_Data(w_data),
      .Instr_Valid(w_valid), .Instr_Ready(w_ready), .Instr_Out(w_out), .Instr_PC(w_pc),
      .Queue_Count(w_cnt)
   );

   typedef struct packed {
      logic [W-1:0] pc;
      logic [W-1:0] instr;
   } ent_t;

   // Reference model: the queue of delivered entries, next fetch address,
   // the request currently shown to memory and whether its data is unwanted.
   ent_t         q[$];
   logic [W-1:0] m_pc, m_addr;
   bit           m_req, m_stale;
   int           wait_left;
   int           total  = 0;
   int           passed = 0;
   int           failed = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset(input logic [W-1:0] rpc);
      q.delete();
      m_pc    = rpc;
      m_addr  = '0;
      m_req   = 1'b0;
      m_stale = 1'b0;
   endtask

   task automatic model_step();
      bit   pop_now;
      ent_t e;
      pop_now = (q.size() != 0) && ready;
      if (jump_en) begin
         q.delete();
         m_pc = jump_addr;
         if (!m_req) begin
            m_req  = 1'b1;
            m_addr = m_pc;
         end else if (!m_stale && ack) begin
            m_addr = m_pc;
         end else if (!m_stale) begin
            m_stale = 1'b1;
         end
      end else begin
         if (pop_now) void'(q.pop_front());
         if (!m_req) begin
            if (q.size() < DEPTH) begin
               m_req  = 1'b1;
               m_addr = m_pc;
            end
         end else if (m_stale) begin
            if (ack) begin
               m_stale = 1'b0;
               m_addr  = m_pc;
            end
         end else if (ack) begin
            e.pc    = m_pc;
            e.instr = mdata;
            q.push_back(e);
            m_pc = m_pc + 1'b1;
            if (q.size() < DEPTH) m_addr = m_pc;
            else m_req = 1'b0;
         end
      end
   endtask

   task automatic check_all(input string tag);
      logic [W-1:0] e_out, e_pc;
      e_out = (q.size() != 0) ? q[0].instr : '0;
      e_pc  = (q.size() != 0) ? q[0].pc    : '0;
      chk({tag, ".req"},   32'(req),   32'(m_req));
      chk({tag, ".addr"},  32'(addr),  32'(m_addr));
      chk({tag, ".valid"}, 32'(valid), 32'(q.size() != 0));
      chk({tag, ".count"}, 32'(qcnt),  32'(q.size()));
      chk({tag, ".out"},   32'(iout),  32'(e_out));
      chk({tag, ".pc"},    32'(ipc),   32'(e_pc));
   endtask

   task automatic step(input string tag);
      model_step();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic mem_zero_wait();
      ack   = m_req;
      mdata = W'($urandom);
   endtask

   task automatic mem_random();
      ack = 1'b0;
      if (m_req) begin
         if (wait_left == 0) begin
            ack       = 1'b1;
            mdata     = W'($urandom);
            wait_left = int'($urandom_range(0, 3));
         end else begin
            wait_left--;
         end
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, ".req"},   32'(req),   32'd0);
      chk({tag, ".addr"},  32'(addr),  32'd0);
      chk({tag, ".valid"}, 32'(valid), 32'd0);
      chk({tag, ".count"}, 32'(qcnt),  32'd0);
      chk({tag, ".out"},   32'(iout),  32'd0);
      chk({tag, ".pc"},    32'(ipc),   32'd0);
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      jump_en   = 1'b0;
      jump_addr = '0;
      ack       = 1'b0;
      ready     = 1'b0;
      mdata     = '0;
      w_ack     = 1'b0;
      wait_left = 0;
      #2;
      check_zero("rst_async");
      @(posedge clk);
      #1;
      model_reset(20'h00000);
      check_all("rst_hold");
      rst_n = 1'b1;
   endtask

   initial begin
      w_ready = 1'b1;
      w_jump  = 1'b0;
      w_jaddr = '0;
      w_data  = 20'h0BEEF;
      #1;

      // Zero-wait memory, consumer always ready: back-to-back delivery
      do_reset();
      ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         mem_zero_wait();
         step("stream");
         if (i == 1) begin
            chk("stream.first_req",  32'(req),  32'd1);
            chk("stream.first_addr", 32'(addr), 32'd0);
         end else begin
            chk("stream.no_bubble", 32'(valid), 32'd1);
            chk("stream.pc_seq",    32'(ipc),   32'(i - 2));
         end
      end

      // Consumer stalled: queue fills to DEPTH, then one pop restarts fetch
      do_reset();
      for (int i = 0; i < 8; i++) begin
         mem_zero_wait();
         step("fill");
      end
      chk("fill.count_full", 32'(qcnt), 32'd4);
      chk("fill.req_low",    32'(req),  32'd0);
      ready = 1'b1;
      mem_zero_wait();
      step("fill_pop");
      chk("fill_pop.req",  32'(req),  32'd1);
      chk("fill_pop.addr", 32'(addr), 32'd4);
      ready = 1'b0;

      // Jump while a slow (3-cycle) fetch is outstanding
      do_reset();
      ack = 1'b0;
      step("slow");
      ack = 1'b1; mdata = 20'h11111; step("slow");
      ack = 1'b1; mdata = 20'h22222; step("slow");
      ack = 1'b0; step("slow_wait");
      jump_en = 1'b1; jump_addr = 20'h00100;
      step("slow_jump");
      jump_en = 1'b0;
      chk("slow_jump.valid", 32'(valid), 32'd0);
      chk("slow_jump.held",  32'(addr),  32'h2);
      ack = 1'b1; mdata = 20'hDEAD0; step("slow_stale");
      chk("slow_stale.addr",  32'(addr),  32'h00100);
      chk("slow_stale.valid", 32'(valid), 32'd0);
      ack = 1'b1; mdata = 20'h12345; step("slow_new");
      chk("slow_new.pc",    32'(ipc),  32'h00100);
      chk("slow_new.instr", 32'(iout), 32'h12345);

      // Jump coincident with ack and pop
      for (int i = 0; i < 2; i++) begin
         mem_zero_wait();
         step("coin_fill");
      end
      ready = 1'b1; jump_en = 1'b1; jump_addr = 20'h0ABCD;
      mem_zero_wait();
      step("coin_jump");
      jump_en = 1'b0;
      chk("coin_jump.count", 32'(qcnt), 32'd0);
      chk("coin_jump.addr",  32'(addr), 32'h0ABCD);
      mem_zero_wait();
      step("coin_next");
      chk("coin_next.pc", 32'(ipc), 32'h0ABCD);

      // Reset asserted between edges while a stale fetch drains
      do_reset();
      ack = 1'b0;
      step("disc");
      jump_en = 1'b1; jump_addr = 20'h00777;
      step("disc_jump");
      jump_en = 1'b0;
      step("disc_hold");
      #2;
      rst_n = 1'b0;
      #1;
      check_zero("disc_rst");
      model_reset(20'h00000);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step("disc_release");
      chk("disc_release.addr", 32'(addr), 32'h0);
      chk("disc_release.req",  32'(req),  32'd1);

      // Random traffic: variable memory latency, stalls and jumps
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         ready   = ($urandom_range(0, 3) != 0);
         jump_en = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 3) == 0) jump_addr = 20'hFFFFC | W'($urandom_range(0, 3));
         else jump_addr = W'($urandom);
         mem_random();
         step("rand");
      end

      // Address wrap from RESET_PC = 0xFFFFE on the second instance
      do_reset();
      w_ack = 1'b1;
      @(posedge clk); #1;
      chk("wrap.req0",  32'(w_req),  32'd1);
      chk("wrap.addr0", 32'(w_addr), 32'hFFFFE);
      @(posedge clk); #1;
      chk("wrap.addr1", 32'(w_addr), 32'hFFFFF);
      chk("wrap.pc1",   32'(w_pc),   32'hFFFFE);
      chk("wrap.out1",  32'(w_out),  32'h0BEEF);
      @(posedge clk); #1;
      chk("wrap.addr2", 32'(w_addr), 32'h00000);
      chk("wrap.pc2",   32'(w_pc),   32'hFFFFF);
      @(posedge clk); #1;
      chk("wrap.addr3", 32'(w_addr), 32'h00001);
      chk("wrap.pc3",   32'(w_pc),   32'h00000);
      chk("wrap.count", 32'(w_cnt),  32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/instruction_prefetch_queue.md
# instruction_prefetch_queue

Front-end fetch block sitting directly upstream of the `IF_ID` pipeline register. It replaces free-running PC fetch with a request/acknowledge instruction-memory port and a small FIFO of prefetched 20-bit instructions, each tagged with its PC. Decode drains the FIFO through a valid/ready handshake. A jump from the pipeline flushes the FIFO and redirects fetch.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `WIDTH`, 20: instruction and address width.
- `RESET_PC`, 0: first fetch address after reset.

Ports:
- `Clock`  in  1  sole clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-low; clears all state immediately.
- `JumpEnable`  in  1  single-cycle redirect strobe.
- `JumpAddress`  in  WIDTH  redirect target; sampled when `JumpEnable`=1.
- `IMem_Req`  out  1  fetch request; registered.
- `IMem_Address`  out  WIDTH  fetch address; stable while `IMem_Req`=1.
- `IMem_Ack`  in  1  one-cycle completion pulse; `IMem_Data` is valid in the same cycle.
- `IMem_Data`  in  WIDTH  fetched instruction.
- `Instr_Valid`  out  1  FIFO non-empty.
- `Instr_Ready`  in  1  consumer accepts the head entry.
- `Instr_Out`  out  WIDTH  head instruction (show-ahead).
- `Instr_PC`  out  WIDTH  PC of the head instruction.
- `Queue_Count`  out  log2(DEPTH)+1  current occupancy.

## Operation
- `fetch_pc`: the next address to request. It increments by 1 per accepted instruction and wraps from 0xFFFFF to 0.
- At most one memory transaction is outstanding at any time.
- A transaction completes in any cycle where `IMem_Req`=1 and `IMem_Ack`=1. A zero-wait ack in the first `Req` cycle is legal.
- FSM states: IDLE, FETCH, DISCARD.
- **IDLE** (`IMem_Req`=0):
  - Go to FETCH when occupancy after this cycle's pop is < `DEPTH`, or when `JumpEnable`=1.
- **FETCH** (`IMem_Req`=1, `IMem_Address`=`fetch_pc`):
  - On `Ack` without jump: push {`fetch_pc`, `IMem_Data`} and increment `fetch_pc`.
  - Then stay in FETCH (back-to-back, `Req` stays high) if the next occupancy is < `DEPTH`; otherwise go to IDLE.
- **DISCARD** (`IMem_Req`=1, address held): a stale transaction is draining.
  - On `Ack`: drop the data and go to FETCH.
- **Pop:** when `Instr_Valid` and `Instr_Ready` are both 1, remove the head entry.
- **Push and pop in the same cycle:** occupancy is unchanged. A push into a full FIFO cannot occur, because a slot is reserved before FETCH is entered.
- **Jump** (top priority):
  - Occupancy goes to 0 and `fetch_pc` ← `JumpAddress`. Any same-cycle pop or push is discarded.
  - Jump in FETCH without same-cycle `Ack`: go to DISCARD.
  - Jump in FETCH with same-cycle `Ack`: drop the data and go to FETCH at the new address.
  - Jump in DISCARD: update the target and stay in DISCARD.
  - Jump in IDLE: go to FETCH.
- **Reset asserted:**
  - Every output goes to 0: `IMem_Req`, `IMem_Address`, `Instr_Valid`, `Instr_Out`, `Instr_PC`, `Queue_Count`.
  - State goes to IDLE and `fetch_pc` goes to `RESET_PC`.
  - An outstanding transaction is abandoned. The memory must tolerate `Req` dropping at any time.

## Timing
- First `IMem_Req`=1 occurs one cycle after `Reset` deasserts, with address `RESET_PC`.
- Ack in cycle N → `Instr_Valid`=1 and the entry visible at the head in cycle N+1.
- Jump in cycle N → `Instr_Valid`=0 in N+1.
  - New-target `Req` in N+1 if no discard is pending.
  - Otherwise, new-target `Req` in the cycle after the stale `Ack`.
- With zero-wait memory and `Instr_Ready` held at 1, sustained throughput is 1 instruction/cycle.
- `IMem_Req`, `IMem_Address` and `Queue_Count` are registered; `Instr_Out` and `Instr_PC` are read from storage at the head pointer.

## Structure
- Shared package `fetch_pkg`:
  - `WIDTH` constant.
  - FSM enum {IDLE, FETCH, DISCARD}.
  - Packed `fetch_entry_t` = {pc, instr}.
- Sub-module `instr_fifo`:
  - Synchronous FIFO of `fetch_entry_t`.
  - Ports: push, pop, flush, head, count.
  - Circular pointers, plus a count of width log2(DEPTH)+1.
- The top level holds the FSM, `fetch_pc` and the port registers.

## Test plan
- **Reset, zero-wait memory, `Ready`=1:**
  - Required: `Req` rises one cycle after release; addresses 0, 1, 2, …
  - `Instr_PC` follows 0, 1, 2 one cycle behind each ack, with no bubbles.
- **`Ready`=0, zero-wait memory:**
  - Required: `Queue_Count` reaches 4 and `Req` drops.
  - Then a single pop → `Req` reasserts with address 4.
- **Jump to 0x00100 while FETCH waits on a 3-cycle ack:**
  - Required: `Valid`=0 next cycle and the stale data is never visible.
  - The next `Req` carries 0x00100, and the first popped `Instr_PC` is 0x00100.
- **Jump coincident with `Ack` and pop:**
  - Required: nothing is pushed or visible from the old stream; `Queue_Count`=0.
  - The next address is the jump target.
- **Wrap:** `RESET_PC`=0xFFFFE → required addresses 0xFFFFE, 0xFFFFF, 0x00000.
- **Reset asserted mid-DISCARD:**
  - Required: all outputs are 0 immediately, without a clock edge.
  - After release, the first `Req` is at `RESET_PC`.
